// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard between decode and EX for an NLANE-wide in-order pipeline.
// Tracks in-flight destinations, raises a bundle-wide stall on RAW/WAW hazards, counts stall cycles.
module issue_scoreboard #(
    parameter int NLANE = 2,
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int CW    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NLANE-1:0]      issue_valid,
    input  logic [NLANE*AW-1:0]   issue_rs,
    input  logic [NLANE*AW-1:0]   issue_rt,
    input  logic [NLANE-1:0]      issue_rs_use,
    input  logic [NLANE-1:0]      issue_rt_use,
    input  logic [NLANE-1:0]      issue_wr,
    input  logic [NLANE*AW-1:0]   issue_wrreg,
    input  logic                  kill,
    output logic                  stall,
    output logic [NLANE-1:0]      issue_accept,
    output logic [2**AW-1:0]      busy,
    output logic [CW-1:0]         stall_cnt
);

    localparam int NREG = 2**AW;
    // The oldest (write-back) stage never hazards a reader, so it exists only as a term of busy.
    localparam int LIVE = DEPTH - 1;

    logic [LIVE-1:0][NLANE-1:0]          r_v;
    logic [LIVE-1:0][NLANE-1:0][AW-1:0]  r_reg;
    logic [NREG-1:0]                     r_busy;
    logic [CW-1:0]                       r_stall_cnt;

    logic [NLANE-1:0][AW-1:0]            w_rs;
    logic [NLANE-1:0][AW-1:0]            w_rt;
    logic [NLANE-1:0][AW-1:0]            w_wd;
    logic [NLANE-1:0]                    w_rs_act;
    logic [NLANE-1:0]                    w_rt_act;
    logic [NLANE-1:0]                    w_wr_act;
    logic [LIVE-1:0][NLANE-1:0]          w_v_eff;
    logic [NLANE-1:0]                    w_hz;
    logic                                w_stall;
    logic [LIVE-1:0][NLANE-1:0]          w_v_nxt;
    logic [LIVE-1:0][NLANE-1:0][AW-1:0]  w_reg_nxt;
    logic [NREG-1:0]                     w_busy_nxt;

    assign w_rs = issue_rs;
    assign w_rt = issue_rt;
    assign w_wd = issue_wrreg;

    always_comb begin
        for (int i = 0; i < NLANE; i++) begin
            w_rs_act[i] = issue_rs_use[i] & (w_rs[i] != '0);
            w_rt_act[i] = issue_rt_use[i] & (w_rt[i] != '0);
            w_wr_act[i] = issue_wr[i] & (w_wd[i] != '0);
        end
    end

    // A kill squashes the bundle that entered stage 0 on the previous edge.
    always_comb begin
        w_v_eff = r_v;
        if (kill) w_v_eff[0] = '0;
    end

    always_comb begin
        w_hz = '0;
        for (int i = 0; i < NLANE; i++) begin
            if (issue_valid[i]) begin
                for (int k = 0; k < LIVE; k++) begin
                    for (int j = 0; j < NLANE; j++) begin
                        if (w_v_eff[k][j] &&
                            ((w_rs_act[i] && (r_reg[k][j] == w_rs[i])) ||
                             (w_rt_act[i] && (r_reg[k][j] == w_rt[i]))))
                            w_hz[i] = 1'b1;
                    end
                end
                for (int j = 0; j < i; j++) begin
                    if (issue_valid[j] && w_wr_act[j] &&
                        ((w_rs_act[i] && (w_wd[j] == w_rs[i])) ||
                         (w_rt_act[i] && (w_wd[j] == w_rt[i])) ||
                         (w_wr_act[i] && (w_wd[j] == w_wd[i]))))
                        w_hz[i] = 1'b1;
                end
            end
        end
    end

    assign w_stall      = |w_hz;
    assign stall        = w_stall;
    assign issue_accept = issue_valid & {NLANE{~w_stall}};

    always_comb begin
        w_busy_nxt = '0;
        for (int j = 0; j < NLANE; j++) begin
            w_v_nxt[0][j]   = issue_accept[j] & w_wr_act[j];
            w_reg_nxt[0][j] = w_wd[j];
        end
        for (int k = 1; k < LIVE; k++) begin
            w_v_nxt[k]   = w_v_eff[k-1];
            w_reg_nxt[k] = r_reg[k-1];
        end
        for (int j = 0; j < NLANE; j++) begin
            if (w_v_nxt[0][j]) w_busy_nxt[w_wd[j]] = 1'b1;
            for (int k = 0; k < LIVE; k++) begin
                if (w_v_eff[k][j]) w_busy_nxt[r_reg[k][j]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v         <= '0;
            r_busy      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_v    <= w_v_nxt;
            r_busy <= w_busy_nxt;
            if (w_stall && (r_stall_cnt != {CW{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        r_reg <= w_reg_nxt;
    end

    assign busy      = r_busy;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized and directed bench for issue_scoreboard against a queue-of-writes model.
// A second instance with a 4-bit counter exercises stall-count saturation.
module tb_issue_scoreboard;

    localparam int NL = 2;
    localparam int AW = 5;
    localparam int DP = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [NL-1:0]    valid, rsu, rtu, wr;
    logic [NL*AW-1:0] rs, rt, wd;
    logic             kill;

    logic             stall, stall4;
    logic [NL-1:0]    acc, acc4;
    logic [31:0]      busy, busy4;
    logic [15:0]      cnt;
    logic [3:0]       cnt4;

    always #5 clk = ~clk;

    issue_scoreboard #(.NLANE(NL), .AW(AW), .DEPTH(DP), .CW(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(valid), .issue_rs(rs), .issue_rt(rt),
        .issue_rs_use(rsu), .issue_rt_use(rtu), .issue_wr(wr), .issue_wrreg(wd),
        .kill(kill), .stall(stall), .issue_accept(acc), .busy(busy), .stall_cnt(cnt));

    issue_scoreboard #(.NLANE(NL), .AW(AW), .DEPTH(DP), .CW(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .issue_valid(valid), .issue_rs(rs), .issue_rt(rt),
        .issue_rs_use(rsu), .issue_rt_use(rtu), .issue_wr(wr), .issue_wrreg(wd),
        .kill(kill), .stall(stall4), .issue_accept(acc4), .busy(busy4), .stall_cnt(cnt4));

    typedef struct {
        int cyc;
        int rg;
        bit killed;
    } ent_t;

    ent_t        q[$];
    int          cur = 0;
    logic [31:0] m_busy = '0;
    int          m_cnt = 0;
    int          m_cnt4 = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic        s_stall;
    logic [31:0] s_busy;
    int          s_cnt, s_cnt4;

    function automatic int lane(input logic [NL*AW-1:0] v, input int i);
        return int'(v[i*AW +: AW]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cur);
    endtask

    task automatic idle();
        valid = '0; rsu = '0; rtu = '0; wr = '0;
        rs = '0; rt = '0; wd = '0; kill = 1'b0;
    endtask

    task automatic set_lane(input int i, input int rs_, input bit rsu_, input int rt_,
                            input bit rtu_, input bit wr_, input int wd_);
        valid[i] = 1'b1;
        rs[i*AW +: AW] = AW'(rs_); rsu[i] = rsu_;
        rt[i*AW +: AW] = AW'(rt_); rtu[i] = rtu_;
        wr[i] = wr_; wd[i*AW +: AW] = AW'(wd_);
    endtask

    // One pipeline cycle: evaluate the model, compare, then advance across the clock edge.
    task automatic cycle();
        logic          exp_stall;
        logic [NL-1:0] exp_acc;
        int            s, age;
        #2;
        if (!rst_n) begin
            q.delete(); m_busy = '0; m_cnt = 0; m_cnt4 = 0;
        end
        if (kill) begin
            foreach (q[k]) if (q[k].cyc == cur - 1) q[k].killed = 1'b1;
        end
        exp_stall = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (valid[i]) begin
                for (int side = 0; side < 2; side++) begin
                    s = side ? lane(rt, i) : lane(rs, i);
                    if ((side ? rtu[i] : rsu[i]) && s != 0) begin
                        foreach (q[k]) begin
                            age = cur - q[k].cyc;
                            if (!q[k].killed && age >= 1 && age <= DP - 1 && q[k].rg == s)
                                exp_stall = 1'b1;
                        end
                        for (int j = 0; j < i; j++)
                            if (valid[j] && wr[j] && lane(wd, j) == s) exp_stall = 1'b1;
                    end
                end
                for (int j = 0; j < i; j++)
                    if (valid[j] && wr[j] && wr[i] && lane(wd, j) != 0 && lane(wd, j) == lane(wd, i))
                        exp_stall = 1'b1;
            end
        end
        exp_acc = valid & {NL{~exp_stall}};
        s_stall = stall; s_busy = busy; s_cnt = int'(cnt); s_cnt4 = int'(cnt4);
        chk("stall", 32'(stall), 32'(exp_stall));
        chk("accept", 32'(acc), 32'(exp_acc));
        chk("busy", busy, m_busy);
        chk("stall_cnt", 32'(cnt), 32'(m_cnt));
        chk("stall_cw4", 32'(stall4), 32'(exp_stall));
        chk("stall_cnt_cw4", 32'(cnt4), 32'(m_cnt4));
        @(posedge clk);
        if (rst_n) begin
            if (exp_stall) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end else begin
                for (int i = 0; i < NL; i++)
                    if (valid[i] && wr[i] && lane(wd, i) != 0)
                        q.push_back('{cyc: cur, rg: lane(wd, i), killed: 1'b0});
            end
            m_busy = '0;
            foreach (q[k]) if (!q[k].killed && cur - q[k].cyc <= DP - 1) m_busy[q[k].rg] = 1'b1;
            while (q.size() > 0 && cur - q[0].cyc >= DP - 1) void'(q.pop_front());
        end
        cur++;
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (DP) cycle();
    endtask

    initial begin
        int c0;
        rst_n = 1'b0;
        idle();
        #1;
        for (int n = 0; n < 4; n++) begin
            valid = NL'($urandom); rsu = NL'($urandom); rtu = NL'($urandom); wr = NL'($urandom);
            rs = (NL*AW)'($urandom); rt = (NL*AW)'($urandom); wd = (NL*AW)'($urandom);
            kill = 1'($urandom);
            cycle();
        end
        chk("reset_busy", s_busy, 32'd0);
        chk("reset_cnt", 32'(s_cnt), 32'd0);

        idle(); rst_n = 1'b1;
        set_lane(0, 1, 1, 2, 1, 1, 3);
        cycle();
        chk("indep_stall", 32'(s_stall), 32'd0);
        drain();

        // RAW at distance 1..3
        idle(); set_lane(0, 0, 0, 0, 0, 1, 5);
        cycle();
        c0 = s_cnt;
        idle(); set_lane(1, 5, 1, 0, 0, 0, 0);
        cycle(); chk("raw_t1", 32'(s_stall), 32'd1);
        cycle(); chk("raw_t2", 32'(s_stall), 32'd1);
        cycle(); chk("raw_t3", 32'(s_stall), 32'd0);
        chk("raw_cnt", 32'(s_cnt - c0), 32'd2);
        drain();

        idle(); set_lane(0, 0, 0, 0, 0, 1, 7); set_lane(1, 7, 1, 0, 0, 0, 0);
        cycle(); chk("intra_stall", 32'(s_stall), 32'd1);
        idle(); set_lane(0, 1, 1, 0, 0, 1, 8);
        cycle(); chk("intra_next", 32'(s_stall), 32'd0);
        drain();
        idle(); set_lane(0, 7, 1, 0, 0, 0, 0); set_lane(1, 0, 0, 0, 0, 1, 7);
        cycle(); chk("intra_rev", 32'(s_stall), 32'd0);
        drain();

        idle(); set_lane(0, 0, 0, 0, 0, 1, 9); set_lane(1, 0, 0, 0, 0, 1, 9);
        cycle(); chk("waw_stall", 32'(s_stall), 32'd1);
        idle();
        cycle(); chk("waw_next", 32'(s_stall), 32'd0);
        set_lane(0, 0, 0, 0, 0, 1, 0); set_lane(1, 0, 0, 0, 0, 1, 0);
        cycle(); chk("waw_r0", 32'(s_stall), 32'd0);
        idle();
        cycle(); chk("r0_busy", 32'(s_busy[0]), 32'd0);
        drain();

        idle(); set_lane(0, 0, 0, 0, 0, 1, 4);
        cycle(); chk("kill_wr", 32'(s_stall), 32'd0);
        idle(); kill = 1'b1; set_lane(1, 4, 1, 0, 0, 0, 0);
        cycle(); chk("kill_stall", 32'(s_stall), 32'd0);
        idle();
        cycle(); chk("kill_busy", 32'(s_busy[4]), 32'd0);
        drain();

        // reset in the middle of a stall
        idle(); set_lane(0, 0, 0, 0, 0, 1, 6);
        cycle();
        idle(); set_lane(1, 6, 1, 0, 0, 0, 0);
        cycle(); chk("rstmid_stall", 32'(s_stall), 32'd1);
        rst_n = 1'b0;
        cycle(); chk("rstmid_busy", s_busy, 32'd0);
        rst_n = 1'b1;
        cycle(); chk("rstmid_after", 32'(s_stall), 32'd0);
        drain();

        c0 = s_cnt;
        idle(); set_lane(0, 0, 0, 0, 0, 1, 9); set_lane(1, 0, 0, 0, 0, 1, 9);
        repeat (20) cycle();
        idle();
        cycle();
        chk("sat_cnt4", 32'(s_cnt4), 32'd15);
        chk("sat_cnt16", 32'(s_cnt - c0), 32'd20);

        for (int n = 0; n < 400; n++) begin
            idle();
            for (int i = 0; i < NL; i++)
                set_lane(i, $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7),
                         1'($urandom), 1'($urandom), $urandom_range(0, 7));
            valid = NL'($urandom);
            kill = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
